// File: rtl/native_arb_pkg.sv
// Shared types for the native memory port arbiter.
// Latency: n/a. Backpressure: n/a.
// Holds the FSM encoding and the native bus field widths.
package native_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int WEN_W = 4;

endpackage

// File: rtl/native_arb_rr_pick.sv
// Combinational picker: first set request at or above i_base, wrapping; lowest index when i_fixed.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
module native_arb_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_base,
    input  logic             i_fixed,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Descending scan so the candidate closest to the start point is assigned last and wins.
    always_comb begin
        int cand;
        o_found = |i_req;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = i_fixed ? k : (int'(i_base) + k) % NREQ;
            if (i_req[cand[IDX_W-1:0]]) begin
                o_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/native_arb.sv
// Shares one native memory port among NREQ requesters, grant locked for the whole transaction.
// Latency: 1 cycle s_val->m_val (registered grant); s_rdy combinational from m_rdy.
// Backpressure: requesters wait on s_val until their s_rdy; one idle cycle after each completion.
module native_arb
    import native_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int FIXED_PRIO = 0,
    parameter int IDX_W      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       s_val,
    output logic [NREQ-1:0]       s_rdy,
    input  logic [ADR_W*NREQ-1:0] s_adr,
    input  logic [WEN_W*NREQ-1:0] s_wen,
    input  logic [DAT_W*NREQ-1:0] s_wdat,
    output logic [DAT_W-1:0]      s_rdat,
    output logic                  m_val,
    input  logic                  m_rdy,
    output logic [ADR_W-1:0]      m_adr,
    output logic [WEN_W-1:0]      m_wen,
    output logic [DAT_W-1:0]      m_wdat,
    input  logic [DAT_W-1:0]      m_rdat,
    output logic [IDX_W-1:0]      gnt_idx
);

    state_t           r_state;
    logic [IDX_W-1:0] r_gnt;
    logic [IDX_W-1:0] r_last;

    logic [IDX_W-1:0] w_base;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_grant;
    logic             w_done;

    assign w_base  = (r_last == IDX_W'(NREQ - 1)) ? '0 : r_last + 1'b1;
    assign w_grant = (r_state == ST_IDLE) && w_found;
    // m_rdy outside BUSY is a stray pulse and must not complete anything.
    assign w_done  = (r_state == ST_BUSY) && m_rdy;

    native_arb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (s_val),
        .i_base  (w_base),
        .i_fixed (FIXED_PRIO != 0),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= IDX_W'(NREQ - 1);
        end else if (w_grant) begin
            r_state <= ST_BUSY;
            r_gnt   <= w_win;
            if (FIXED_PRIO == 0) begin
                r_last <= w_win;
            end
        end else if (w_done) begin
            r_state <= ST_IDLE;
        end
    end

    assign m_val   = (r_state == ST_BUSY);
    assign gnt_idx = r_gnt;
    assign s_rdat  = m_rdat;

    // Request fields are only forwarded while owned; IDLE drives zeros downstream.
    always_comb begin
        m_adr  = '0;
        m_wen  = '0;
        m_wdat = '0;
        s_rdy  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (m_val && (r_gnt == IDX_W'(k))) begin
                m_adr  = s_adr[ADR_W*k +: ADR_W];
                m_wen  = s_wen[WEN_W*k +: WEN_W];
                m_wdat = s_wdat[DAT_W*k +: DAT_W];
            end
            s_rdy[k] = w_done && (r_gnt == IDX_W'(k));
        end
    end

endmodule

// File: tb/tb_native_arb.sv
// Bench for native_arb: 3-requester round-robin instance and 2-requester fixed-priority instance.
module tb_native_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  a_sval, a_srdy;
    logic [95:0] a_sadr, a_swdat;
    logic [11:0] a_swen;
    logic [31:0] a_srdat, a_madr, a_mwdat, a_mrdat;
    logic        a_mval, a_mrdy;
    logic [3:0]  a_mwen;
    logic [1:0]  a_gnt;

    logic [1:0]  b_sval, b_srdy;
    logic [63:0] b_sadr, b_swdat;
    logic [7:0]  b_swen;
    logic [31:0] b_srdat, b_madr, b_mwdat, b_mrdat;
    logic        b_mval, b_mrdy;
    logic [3:0]  b_mwen;
    logic        b_gnt;

    int n_cmp = 0;
    int n_err = 0;

    native_arb #(.NREQ(3), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .s_val(a_sval), .s_rdy(a_srdy), .s_adr(a_sadr),
        .s_wen(a_swen), .s_wdat(a_swdat), .s_rdat(a_srdat), .m_val(a_mval), .m_rdy(a_mrdy),
        .m_adr(a_madr), .m_wen(a_mwen), .m_wdat(a_mwdat), .m_rdat(a_mrdat), .gnt_idx(a_gnt)
    );

    native_arb #(.NREQ(2), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .s_val(b_sval), .s_rdy(b_srdy), .s_adr(b_sadr),
        .s_wen(b_swen), .s_wdat(b_swdat), .s_rdat(b_srdat), .m_val(b_mval), .m_rdy(b_mrdy),
        .m_adr(b_madr), .m_wen(b_mwen), .m_wdat(b_mwdat), .m_rdat(b_mrdat), .gnt_idx(b_gnt)
    );

    task automatic a_set(input int i, input logic [31:0] adr, input logic [3:0] wen,
                         input logic [31:0] wdat);
        a_sadr[32*i +: 32]  = adr;
        a_swen[4*i +: 4]    = wen;
        a_swdat[32*i +: 32] = wdat;
    endtask

    task automatic clear_inputs();
        a_sval = '0; a_sadr = '0; a_swen = '0; a_swdat = '0; a_mrdy = 1'b0; a_mrdat = '0;
        b_sval = '0; b_sadr = '0; b_swen = '0; b_swdat = '0; b_mrdy = 1'b0; b_mrdat = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_mval === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_mval === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        a_mrdy = 1'b1;
        #1;
        n_cmp++; if (a_mval !== 1'b0) begin n_err++; $display("FAIL rst_mval got=%0b exp=0", a_mval); end
        n_cmp++; if (a_srdy !== 3'b000) begin n_err++; $display("FAIL rst_srdy got=%b exp=000", a_srdy); end
        n_cmp++; if ({a_madr, a_mwen, a_mwdat} !== 68'd0) begin n_err++; $display("FAIL rst_mbus got=%h/%h/%h exp=0", a_madr, a_mwen, a_mwdat); end
        n_cmp++; if (a_gnt !== 2'd0) begin n_err++; $display("FAIL rst_gnt got=%0d exp=0", a_gnt); end
        n_cmp++; if (b_mval !== 1'b0 || b_gnt !== 1'b0) begin n_err++; $display("FAIL rst_fp got=%0b/%0d exp=0/0", b_mval, b_gnt); end
        a_mrdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        a_set(0, 32'h8000_0000, 4'h0, 32'h0);
        a_sval = 3'b001;
        #1;
        n_cmp++; if (a_mval !== 1'b0) begin n_err++; $display("FAIL rd_nocomb got=%0b exp=0", a_mval); end
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b1 || a_madr !== 32'h8000_0000 || a_mwen !== 4'h0 || a_gnt !== 2'd0)
            begin n_err++; $display("FAIL rd_req got=%0b/%h/%h/%0d exp=1/80000000/0/0", a_mval, a_madr, a_mwen, a_gnt); end
        a_mrdy = 1'b1; a_mrdat = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (a_srdy !== 3'b001 || a_srdat !== 32'hDEAD_BEEF)
            begin n_err++; $display("FAIL rd_done got=%b/%h exp=001/deadbeef", a_srdy, a_srdat); end
        @(negedge clk);
        a_mrdy = 1'b0; a_sval = 3'b000;
        n_cmp++; if (a_mval !== 1'b0 || a_madr !== 32'h0) begin n_err++; $display("FAIL rd_idle got=%0b/%h exp=0/0", a_mval, a_madr); end
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        a_set(0, 32'h0000_1000, 4'h0, 32'hAAAA_0000);
        a_set(1, 32'h0000_2000, 4'hF, 32'h1234_5678);
        a_sval = 3'b011;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            wait_a(ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL cont_timeout k=%0d got=timeout exp=m_val", k); end
            n_cmp++; if (a_gnt !== 2'(e)) begin n_err++; $display("FAIL cont_gnt k=%0d got=%0d exp=%0d", k, a_gnt, e); end
            @(negedge clk);
            n_cmp++; if (a_mwen !== (e == 1 ? 4'hF : 4'h0) || a_mwdat !== (e == 1 ? 32'h1234_5678 : 32'hAAAA_0000))
                begin n_err++; $display("FAIL cont_wr k=%0d got=%h/%h exp_gnt=%0d", k, a_mwen, a_mwdat, e); end
            a_mrdy = 1'b1;
            #1;
            n_cmp++; if (a_srdy !== 3'(1 << e)) begin n_err++; $display("FAIL cont_srdy k=%0d got=%b exp=%b", k, a_srdy, 3'(1 << e)); end
            @(negedge clk);
            a_mrdy = 1'b0;
            n_cmp++; if (a_mval !== 1'b0 || a_mwen !== 4'h0) begin n_err++; $display("FAIL cont_turn k=%0d got=%0b/%h exp=0/0", k, a_mval, a_mwen); end
        end
        a_sval = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        bit ok;
        do_reset();
        b_sadr = {32'h0000_00B1, 32'h0000_00B0};
        b_sval = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_b(ok);
            n_cmp++; if (ok !== 1'b1 || b_gnt !== 1'b0) begin n_err++; $display("FAIL fp_gnt k=%0d got=%0b/%0d exp=1/0", k, ok, b_gnt); end
            b_mrdy = 1'b1;
            #1;
            n_cmp++; if (b_srdy !== 2'b01) begin n_err++; $display("FAIL fp_srdy k=%0d got=%b exp=01", k, b_srdy); end
            @(negedge clk);
            b_mrdy = 1'b0;
            if (k == 3) b_sval = 2'b10;
        end
        @(negedge clk);
        n_cmp++; if (b_mval !== 1'b1 || b_gnt !== 1'b1 || b_madr !== 32'h0000_00B1)
            begin n_err++; $display("FAIL fp_r1 got=%0b/%0d/%h exp=1/1/000000b1", b_mval, b_gnt, b_madr); end
        b_mrdy = 1'b1;
        #1;
        n_cmp++; if (b_srdy !== 2'b10) begin n_err++; $display("FAIL fp_r1_srdy got=%b exp=10", b_srdy); end
        @(negedge clk);
        b_mrdy = 1'b0; b_sval = 2'b00;
    endtask

    task automatic test_lock();
        bit ok;
        do_reset();
        a_set(0, 32'hA000_0000, 4'h0, 32'h0);
        a_set(1, 32'hB000_0000, 4'h3, 32'h5555_0001);
        a_sval = 3'b001;
        wait_a(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL lock_timeout got=timeout exp=m_val"); end
        a_sval = 3'b011;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (a_mval !== 1'b1 || a_gnt !== 2'd0 || a_madr !== 32'hA000_0000)
                begin n_err++; $display("FAIL lock_hold k=%0d got=%0b/%0d/%h exp=1/0/a0000000", k, a_mval, a_gnt, a_madr); end
            @(negedge clk);
        end
        a_mrdy = 1'b1;
        #1;
        n_cmp++; if (a_srdy !== 3'b001) begin n_err++; $display("FAIL lock_srdy0 got=%b exp=001", a_srdy); end
        @(negedge clk);
        a_mrdy = 1'b0; a_sval = 3'b010;
        n_cmp++; if (a_mval !== 1'b0) begin n_err++; $display("FAIL lock_turn got=%0b exp=0", a_mval); end
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b1 || a_gnt !== 2'd1 || a_madr !== 32'hB000_0000)
            begin n_err++; $display("FAIL lock_next got=%0b/%0d/%h exp=1/1/b0000000", a_mval, a_gnt, a_madr); end
        a_sval = 3'b000;
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (a_mval !== 1'b1 || a_gnt !== 2'd1) begin n_err++; $display("FAIL lock_drop got=%0b/%0d exp=1/1", a_mval, a_gnt); end
        end
        a_mrdy = 1'b1;
        #1;
        n_cmp++; if (a_srdy !== 3'b010) begin n_err++; $display("FAIL lock_srdy1 got=%b exp=010", a_srdy); end
        @(negedge clk);
        a_mrdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b0) begin n_err++; $display("FAIL lock_quiet got=%0b exp=0", a_mval); end
    endtask

    task automatic test_stray_abort();
        bit ok;
        do_reset();
        @(negedge clk);
        a_mrdy = 1'b1; a_mrdat = 32'h1;
        #1;
        n_cmp++; if (a_srdy !== 3'b000) begin n_err++; $display("FAIL stray_srdy got=%b exp=000", a_srdy); end
        @(negedge clk);
        a_mrdy = 1'b0;
        n_cmp++; if (a_mval !== 1'b0) begin n_err++; $display("FAIL stray_mval got=%0b exp=0", a_mval); end
        a_set(0, 32'h0000_00C0, 4'h0, 32'h0);
        a_set(1, 32'h0000_00C1, 4'h1, 32'h7);
        a_sval = 3'b010;
        wait_a(ok);
        n_cmp++; if (ok !== 1'b1 || a_gnt !== 2'd1) begin n_err++; $display("FAIL abort_pre got=%0b/%0d exp=1/1", ok, a_gnt); end
        a_sval = 3'b011;
        rst_n  = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b0 || a_gnt !== 2'd0 || a_srdy !== 3'b000)
            begin n_err++; $display("FAIL abort_rst got=%0b/%0d/%b exp=0/0/000", a_mval, a_gnt, a_srdy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b1 || a_gnt !== 2'd0 || a_madr !== 32'h0000_00C0)
            begin n_err++; $display("FAIL abort_first got=%0b/%0d/%h exp=1/0/000000c0", a_mval, a_gnt, a_madr); end
        a_mrdy = 1'b1;
        #1;
        n_cmp++; if (a_srdy !== 3'b001) begin n_err++; $display("FAIL abort_srdy got=%b exp=001", a_srdy); end
        @(negedge clk);
        a_mrdy = 1'b0; a_sval = 3'b010;
        @(negedge clk);
        n_cmp++; if (a_mval !== 1'b1 || a_gnt !== 2'd1) begin n_err++; $display("FAIL abort_r1 got=%0b/%0d exp=1/1", a_mval, a_gnt); end
        a_mrdy = 1'b1;
        @(negedge clk);
        a_mrdy = 1'b0; a_sval = 3'b000;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        a_set(0, 32'h0000_00D0, 4'h0, 32'h0);
        a_set(2, 32'h0000_00D2, 4'hC, 32'h9);
        a_sval = 3'b101;
        wait_a(ok);
        n_cmp++; if (ok !== 1'b1 || a_gnt !== 2'd0) begin n_err++; $display("FAIL wrap_first got=%0b/%0d exp=1/0", ok, a_gnt); end
        a_mrdy = 1'b1;
        @(negedge clk);
        a_mrdy = 1'b0;
        wait_a(ok);
        n_cmp++; if (ok !== 1'b1 || a_gnt !== 2'd2 || a_madr !== 32'h0000_00D2)
            begin n_err++; $display("FAIL wrap_second got=%0b/%0d/%h exp=1/2/000000d2", ok, a_gnt, a_madr); end
        a_mrdy = 1'b1;
        #1;
        n_cmp++; if (a_srdy !== 3'b100) begin n_err++; $display("FAIL wrap_srdy got=%b exp=100", a_srdy); end
        @(negedge clk);
        a_mrdy = 1'b0; a_sval = 3'b000;
    endtask

    // Transaction-level reference: pending set per requester, owner, and last winner.
    task automatic test_random();
        bit          busy;
        int          owner;
        int          last;
        bit          pend [3];
        logic [31:0] radr [3];
        logic [3:0]  rwen [3];
        logic [31:0] rwdat [3];
        logic [31:0] rdat;
        logic [2:0]  exp_rdy;
        do_reset();
        busy = 1'b0; owner = 0; last = 2;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; radr[i] = '0; rwen[i] = '0; rwdat[i] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            n_cmp++; if (a_mval !== busy) begin n_err++; $display("FAIL rnd_mval cyc=%0d got=%0b exp=%0b", cyc, a_mval, busy); end
            if (busy) begin
                n_cmp++; if (a_gnt !== 2'(owner) || a_madr !== radr[owner] || a_mwen !== rwen[owner] || a_mwdat !== rwdat[owner])
                    begin n_err++; $display("FAIL rnd_bus cyc=%0d got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", cyc, a_gnt, a_madr, a_mwen, a_mwdat, owner, radr[owner], rwen[owner], rwdat[owner]); end
            end else begin
                n_cmp++; if ({a_madr, a_mwen, a_mwdat} !== 68'd0)
                    begin n_err++; $display("FAIL rnd_idlebus cyc=%0d got=%h/%h/%h exp=0", cyc, a_madr, a_mwen, a_mwdat); end
            end
            a_mrdy  = busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            rdat    = $urandom;
            a_mrdat = rdat;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1; radr[i] = $urandom; rwen[i] = 4'($urandom); rwdat[i] = $urandom;
                end
                a_set(i, radr[i], rwen[i], rwdat[i]);
                a_sval[i] = pend[i];
            end
            #1;
            exp_rdy = (busy && a_mrdy) ? 3'(1 << owner) : 3'b000;
            n_cmp++; if (a_srdy !== exp_rdy || a_srdat !== rdat)
                begin n_err++; $display("FAIL rnd_srdy cyc=%0d got=%b/%h exp=%b/%h", cyc, a_srdy, a_srdat, exp_rdy, rdat); end
            if (busy && a_mrdy) begin
                busy = 1'b0;
                pend[owner] = 1'b0;
            end else if (!busy) begin
                for (int off = 1; off <= 3; off++) begin
                    int c;
                    c = (last + off) % 3;
                    if (pend[c]) begin owner = c; last = c; busy = 1'b1; break; end
                end
            end
        end
        @(negedge clk);
        a_sval = '0; a_mrdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fixed_prio();
        test_lock();
        test_stray_abort();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
